// File: rtl/riscv_pkg.sv
// Shared types and helpers for the load/store datapath.
// Access sizes, LSU states and strobe/alignment helpers.
package riscv_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_e;

    function automatic logic [7:0] size_mask(mem_size_e sz);
        logic [7:0] m;
        m = 8'h01;
        unique case (sz)
            SZ_B: m = 8'h01;
            SZ_H: m = 8'h03;
            SZ_W: m = 8'h0F;
            SZ_D: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(mem_size_e sz, logic [2:0] off);
        logic r;
        r = 1'b0;
        unique case (sz)
            SZ_B: r = 1'b0;
            SZ_H: r = off[0];
            SZ_W: r = |off[1:0];
            SZ_D: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store shift/strobes and load extract/extend.
// Purely combinational so it can be shared with a future cache.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_size_e        size_i,
    input  logic [2:0]       off_i,
    input  logic             uns_i,
    input  logic [XLEN-1:0]  st_data_i,
    output logic [XLEN-1:0]  st_data_o,
    output logic [7:0]       st_strb_o,
    input  logic [XLEN-1:0]  ld_data_i,
    output logic [XLEN-1:0]  ld_data_o
);

    logic [5:0]      sh;
    logic [XLEN-1:0] ld_raw;

    assign sh        = {off_i, 3'b000};
    assign st_data_o = st_data_i << sh;
    assign st_strb_o = size_mask(size_i) << off_i;
    assign ld_raw    = ld_data_i >> sh;

    always_comb begin
        ld_data_o = ld_raw;
        unique case (size_i)
            SZ_B: ld_data_o = uns_i ? {56'b0, ld_raw[7:0]}
                                    : {{56{ld_raw[7]}}, ld_raw[7:0]};
            SZ_H: ld_data_o = uns_i ? {48'b0, ld_raw[15:0]}
                                    : {{48{ld_raw[15]}}, ld_raw[15:0]};
            SZ_W: ld_data_o = uns_i ? {32'b0, ld_raw[31:0]}
                                    : {{32{ld_raw[31]}}, ld_raw[31:0]};
            SZ_D: ld_data_o = ld_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding req/gnt/rvalid port with
// alignment, strobes and load extension; one wb beat per load/ALU op.
module load_store_unit #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       addr_i,
    input  logic [XLEN-1:0]       store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [7:0]            mem_wstrb_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  misaligned_o,
    output logic                  busy_o
);

    import riscv_pkg::*;

    lsu_state_e            state_q, state_d;
    logic [XLEN-1:0]       maddr_q, maddr_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic [2:0]            off_q, off_d;
    mem_size_e             size_q, size_d;
    logic                  uns_q, uns_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  wbv_q, wbv_d;
    logic [REG_ADDR_W-1:0] wbrd_q, wbrd_d;
    logic [XLEN-1:0]       wbdata_q, wbdata_d;
    logic                  mis_q, mis_d;

    mem_size_e       al_size;
    logic [2:0]      al_off;
    logic [XLEN-1:0] al_wdata, al_ldata;
    logic [7:0]      al_strb;
    logic            accept, is_mem, is_st, finish;

    // Idle: align the incoming op; otherwise the captured one.
    assign al_size = (state_q == IDLE) ? mem_size_e'(funct3_i[1:0]) : size_q;
    assign al_off  = (state_q == IDLE) ? addr_i[2:0] : off_q;

    lsu_align u_align (
        .size_i    (al_size),
        .off_i     (al_off),
        .uns_i     (uns_q),
        .st_data_i (store_data_i),
        .st_data_o (al_wdata),
        .st_strb_o (al_strb),
        .ld_data_i (mem_rdata_i),
        .ld_data_o (al_ldata)
    );

    assign accept = valid_i && ready_o;
    assign is_mem = mem_read_i || mem_write_i;
    assign is_st  = mem_write_i && !mem_read_i;

    always_comb begin
        state_d  = state_q;
        maddr_d  = maddr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        rd_d     = rd_q;
        wbv_d    = 1'b0;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        mis_d    = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !is_mem) begin
                    wbv_d    = 1'b1;
                    wbdata_d = addr_i;
                    wbrd_d   = rd_i;
                end else if (accept && is_misaligned(al_size, addr_i[2:0])) begin
                    mis_d = 1'b1;
                end else if (accept) begin
                    state_d = REQ;
                    maddr_d = {addr_i[XLEN-1:3], 3'b000};
                    we_d    = is_st;
                    wdata_d = is_st ? al_wdata : '0;
                    wstrb_d = is_st ? al_strb : 8'h00;
                    off_d   = addr_i[2:0];
                    size_d  = al_size;
                    uns_d   = funct3_i[2];
                    rd_d    = rd_i;
                end
            end
            REQ: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    finish = 1'b1;
                end else if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: finish = mem_rvalid_i;
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d = IDLE;
            if (!we_q) begin
                wbv_d    = 1'b1;
                wbdata_d = al_ldata;
                wbrd_d   = rd_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            maddr_q  <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= 8'h00;
            off_q    <= 3'd0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            rd_q     <= '0;
            wbv_q    <= 1'b0;
            wbrd_q   <= '0;
            wbdata_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            maddr_q  <= maddr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            rd_q     <= rd_d;
            wbv_q    <= wbv_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            mis_q    <= mis_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wstrb_o  = wstrb_q;
    assign wb_valid_o   = wbv_q;
    assign wb_rd_o      = wbrd_q;
    assign wb_data_o    = wbdata_q;
    assign misaligned_o = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural
// memory-op model and randomized ops/handshake delays.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        mrd;
    logic        mwr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [4:0]  rd;
    logic        req;
    logic        we;
    logic [63:0] maddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [63:0] wbdata;
    logic        mis;
    logic        busy;

    int checks = 0;
    int errors = 0;

    load_store_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .ready_o      (ready),
        .mem_read_i   (mrd),
        .mem_write_i  (mwr),
        .funct3_i     (f3),
        .addr_i       (addr),
        .store_data_i (sdata),
        .rd_i         (rd),
        .mem_req_o    (req),
        .mem_we_o     (we),
        .mem_addr_o   (maddr),
        .mem_wdata_o  (wdata),
        .mem_wstrb_o  (wstrb),
        .mem_gnt_i    (gnt),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata),
        .wb_valid_o   (wbv),
        .wb_rd_o      (wbrd),
        .wb_data_o    (wbdata),
        .misaligned_o (mis),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the addressed bytes, then extend by sign or zero.
    function automatic logic [63:0] exp_load(input logic [63:0] d,
                                             input logic [2:0] fn,
                                             input logic [63:0] a);
        int n;
        logic [63:0] v;
        logic [63:0] m;
        n = 1 << fn[1:0];
        v = d >> (8 * a[2:0]);
        if (n < 8) begin
            m = (64'd1 << (8 * n)) - 64'd1;
            v = v & m;
            if (!fn[2] && v[8*n-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic do_op(input logic r_en, input logic w_en,
                         input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] sd, input logic [4:0] rdi,
                         input int gd, input int rvd,
                         input logic [63:0] rdat, input string tag);
        int n;
        logic is_mem;
        logic is_ld;
        logic misal;
        logic [63:0] e_addr;
        logic [63:0] e_wd;
        logic [7:0]  e_st;
        logic [63:0] e_ld;
        n      = 1 << fn[1:0];
        is_mem = r_en | w_en;
        is_ld  = r_en;
        misal  = is_mem && ((a & 64'(n - 1)) != 64'd0);
        e_addr = {a[63:3], 3'b000};
        e_wd   = sd << (8 * a[2:0]);
        e_st   = 8'(((1 << n) - 1) << a[2:0]);
        e_ld   = exp_load(rdat, fn, a);

        @(negedge clk);
        valid = 1'b1; mrd = r_en; mwr = w_en; f3 = fn;
        addr = a; sdata = sd; rd = rdi;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_at_accept got %b exp 1", tag, ready);
        end
        @(negedge clk);
        valid = 1'b0;
        addr  = 64'($urandom);
        if (!is_mem) begin
            checks++;
            if (wbv !== 1'b1 || wbdata !== a || wbrd !== rdi || req !== 1'b0) begin
                errors++;
                $display("FAIL %s alu_wb got v%b d%h rd%0d req%b exp v1 d%h rd%0d req0",
                         tag, wbv, wbdata, wbrd, req, a, rdi);
            end
        end else if (misal) begin
            checks++;
            if (mis !== 1'b1 || req !== 1'b0 || wbv !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL %s misalign got mis%b req%b wb%b rdy%b exp 1 0 0 1",
                         tag, mis, req, wbv, ready);
            end
        end else begin
            for (int g = 0; g <= gd; g++) begin
                checks++;
                if (req !== 1'b1 || maddr !== e_addr || we !== (w_en & ~r_en) ||
                    ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s req_hold got req%b a%h we%b rdy%b exp 1 %h %b 0",
                             tag, req, maddr, we, ready, e_addr, w_en & ~r_en);
                end
                if (!is_ld) begin
                    checks++;
                    if (wdata !== e_wd || wstrb !== e_st) begin
                        errors++;
                        $display("FAIL %s store_lanes got %h/%h exp %h/%h",
                                 tag, wdata, wstrb, e_wd, e_st);
                    end
                end
                if (g == gd) begin
                    gnt = 1'b1;
                    if (rvd == 0) begin rvalid = 1'b1; rdata = rdat; end
                end else begin
                    rvalid = 1'($urandom % 2);
                end
                @(negedge clk);
                gnt = 1'b0; rvalid = 1'b0; rdata = ~rdat;
            end
            for (int i = 0; i < rvd; i++) begin
                checks++;
                if (req !== 1'b0 || wbv !== 1'b0 || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s resp_wait got req%b wb%b rdy%b exp 0 0 0",
                             tag, req, wbv, ready);
                end
                if (i == rvd - 1) begin rvalid = 1'b1; rdata = rdat; end
                @(negedge clk);
                rvalid = 1'b0; rdata = ~rdat;
            end
            checks++;
            if (wbv !== is_ld || ready !== 1'b1 || req !== 1'b0) begin
                errors++;
                $display("FAIL %s done got wb%b rdy%b req%b exp %b 1 0",
                         tag, wbv, ready, req, is_ld);
            end
            if (is_ld) begin
                checks++;
                if (wbdata !== e_ld || wbrd !== rdi) begin
                    errors++;
                    $display("FAIL %s load_data got %h rd%0d exp %h rd%0d",
                             tag, wbdata, wbrd, e_ld, rdi);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (wbv !== 1'b0 || mis !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse got wb%b mis%b exp 0 0", tag, wbv, mis);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || req !== 1'b0 || we !== 1'b0 || wbv !== 1'b0 ||
            mis !== 1'b0 || busy !== 1'b0 || maddr !== 64'd0 ||
            wdata !== 64'd0 || wstrb !== 8'd0 || wbdata !== 64'd0) begin
            errors++;
            $display("FAIL reset got rdy%b req%b wb%b mis%b a%h s%h exp idle zeros",
                     ready, req, wbv, mis, maddr, wstrb);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd7, 0, 0, 64'd0, "alu");
        do_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd3, 0, 1,
              64'h0000_0000_8000_0000, "lb");
        checks++;
        if (wbdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++; $display("FAIL lb_const got %h exp ffffffffffffff80", wbdata);
        end
        do_op(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 5'd4, 0, 1,
              64'h0000_0000_8000_0000, "lbu");
        checks++;
        if (wbdata !== 64'h80) begin
            errors++; $display("FAIL lbu_const got %h exp 80", wbdata);
        end
        do_op(1'b0, 1'b1, 3'b001, 64'h106, 64'hBEEF, 5'd5, 0, 1, 64'd0, "sh");
        do_op(1'b1, 1'b0, 3'b010, 64'h2002, 64'd0, 5'd6, 0, 1, 64'd0, "lw_mis");
        do_op(1'b1, 1'b0, 3'b011, 64'h3000, 64'd0, 5'd9, 3, 2,
              64'h0123_4567_89AB_CDEF, "ld_stall");
        do_op(1'b1, 1'b1, 3'b010, 64'h4004, 64'hFFFF, 5'd0, 0, 0,
              64'h8765_4321_0000_0000, "rw_as_load");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid = 1'b1; mrd = 1'b0; mwr = 1'b0; addr = 64'hAAAA; rd = 5'd1;
        @(negedge clk);
        addr = 64'hBBBB; rd = 5'd2;
        checks++;
        if (wbv !== 1'b1 || wbdata !== 64'hAAAA || wbrd !== 5'd1 || ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first got v%b %h rd%0d exp 1 aaaa 1", wbv, wbdata, wbrd);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (wbv !== 1'b1 || wbdata !== 64'hBBBB || wbrd !== 5'd2) begin
            errors++; $display("FAIL b2b_second got v%b %h rd%0d exp 1 bbbb 2", wbv, wbdata, wbrd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid = 1'b1; mrd = 1'b1; mwr = 1'b0; f3 = 3'b011; addr = 64'h5000; rd = 5'd8;
        @(negedge clk);
        valid = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        checks++;
        if (busy !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resp got busy%b req%b exp 1 0", busy, req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 64'hDEAD_BEEF;
        checks++;
        if (ready !== 1'b1 || req !== 1'b0 || wbv !== 1'b0 || maddr !== 64'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state got rdy%b req%b wb%b a%h exp 1 0 0 0",
                               ready, req, wbv, maddr);
        end
        @(negedge clk);
        rvalid = 1'b0;
        checks++;
        if (wbv !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stale got wb%b busy%b exp 0 0", wbv, busy);
        end
        do_op(1'b1, 1'b0, 3'b101, 64'h6002, 64'd0, 5'd10, 1, 1,
              64'h0000_0000_F00D_0000, "after_rst");
    endtask

    task automatic test_random();
        logic [1:0]  kind;
        logic [2:0]  fn;
        logic [63:0] a;
        for (int k = 0; k < 60; k++) begin
            kind = 2'($urandom_range(0, 3));
            fn   = 3'($urandom);
            a    = {32'($urandom), 32'($urandom)};
            if ($urandom % 4 != 0) a = a & ~(64'((1 << fn[1:0]) - 1));
            do_op(kind[0], kind[1], fn, a, {32'($urandom), 32'($urandom)},
                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  {32'($urandom), 32'($urandom)}, "rand");
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; mrd = 1'b0; mwr = 1'b0; f3 = 3'd0;
        addr = 64'd0; sdata = 64'd0; rd = 5'd0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 64'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
